// File: rtl/nibble_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_subtractor
// Description : Multi-cycle WIDTH-bit subtractor computing a - b - bin one
//               SLICE-bit slice per clock (LSB slice first) with a chained
//               borrow, valid/ready handshakes and borrow/zero/ovf flags.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Work registers: operands shift right one slice per RUN edge so the
    // current slice is always in the low bits; the result fills from the top.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_zero;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic [SLICE-1:0] w_a_s;
    logic [SLICE-1:0] w_b_s;
    logic [SLICE:0]   w_sum_ext;
    logic [SLICE-1:0] w_sum;
    logic             w_borrow_next;
    logic [WIDTH-1:0] w_res_next;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign zero      = r_zero;
    assign ovf       = r_ovf;

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_cnt == c_LAST);

    // Slice subtract as an add: a_s + ~b_s + ~borrow; a missing carry means borrow.
    assign w_a_s         = r_a[SLICE-1:0];
    assign w_b_s         = r_b[SLICE-1:0];
    assign w_sum_ext     = {1'b0, w_a_s} + {1'b0, ~w_b_s} + {{SLICE{1'b0}}, ~r_borrow};
    assign w_sum         = w_sum_ext[SLICE-1:0];
    assign w_borrow_next = ~w_sum_ext[SLICE];

    generate
        if (NSLICE == 1) begin : g_res_single
            assign w_res_next = w_sum;
        end else begin : g_res_multi
            assign w_res_next = {w_sum, r_res[WIDTH-1:SLICE]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = S_RUN;
            S_RUN:  if (w_last)   w_state_next = S_DONE;
            S_DONE: if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, per-slice processing and result publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_accept) begin
                r_a      <= a;
                r_b      <= b;
                r_borrow <= bin;
                r_cnt    <= '0;
            end else if (r_state == S_RUN) begin
                r_a      <= r_a >> SLICE;
                r_b      <= r_b >> SLICE;
                r_res    <= w_res_next;
                r_borrow <= w_borrow_next;
                r_cnt    <= r_cnt + 1'b1;
                // On the top slice the low operand bits hold the original MSBs.
                if (w_last) begin
                    r_diff <= w_res_next;
                    r_bout <= w_borrow_next;
                    r_zero <= (w_res_next == '0);
                    r_ovf  <= (w_a_s[SLICE-1] != w_b_s[SLICE-1]) &&
                              (w_sum[SLICE-1] != w_a_s[SLICE-1]);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_subtractor
// Description : Self-checking bench for nibble_serial_subtractor: directed
//               cases plus random operands against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_subtractor;

    localparam int W  = 16;
    localparam int NS = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;
    logic         busy;

    int vectors     = 0;
    int miscompares = 0;

    nibble_serial_subtractor #(.WIDTH(W), .SLICE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the full operands.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                         output logic [W-1:0] ed, output logic eb, output logic ez,
                         output logic eo);
        int unsigned full;
        full = int'(ma) - int'(mb) - int'(mbin);
        ed   = full[W-1:0];
        eb   = (int'(ma) < int'(mb) + int'(mbin));
        ez   = (ed == '0);
        eo   = (ma[W-1] != mb[W-1]) && (ed[W-1] != ma[W-1]);
    endtask

    // One complete operation; hold = cycles of out_ready=0 backpressure
    // with fresh operands offered on in_valid during that time.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tbin, input int hold);
        logic [W-1:0] ed;
        logic         eb, ez, eo;
        model(ta, tb_, tbin, ed, eb, ez, eo);
        a = ta; b = tb_; bin = tbin; in_valid = 1'b1; out_ready = 1'b0;
        chk({tag, ".ready_idle"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~ta; b = ~tb_; bin = ~tbin;
        chk({tag, ".ready_run"}, 32'(in_ready), 32'd0);
        chk({tag, ".busy_run"}, 32'(busy), 32'd1);
        for (int i = 1; i < NS; i++) begin
            @(posedge clk); #1;
            chk({tag, ".early_valid"}, 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".ready_done"}, 32'(in_ready), 32'd0);
        chk({tag, ".diff"}, 32'(diff), 32'(ed));
        chk({tag, ".bout"}, 32'(bout), 32'(eb));
        chk({tag, ".zero"}, 32'(zero), 32'(ez));
        chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
            @(posedge clk); #1;
            chk({tag, ".bp_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".bp_ready"}, 32'(in_ready), 32'd0);
            chk({tag, ".bp_diff"}, 32'({diff, bout, zero, ovf}), 32'({ed, eb, ez, eo}));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".hs_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".hs_ready"}, 32'(in_ready), 32'd1);
        chk({tag, ".hs_diff"}, 32'(diff), 32'(ed));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.flags", 32'({diff, bout, zero, ovf, busy}), 32'd0);

        run_op("t1", 16'h1234, 16'h0234, 1'b0, 0);
        run_op("t2", 16'h0000, 16'h0001, 1'b0, 0);
        run_op("t3a", 16'h8000, 16'h0001, 1'b0, 0);
        run_op("t3b", 16'h7FFF, 16'hFFFF, 1'b0, 0);
        run_op("t4", 16'h00F0, 16'h00EF, 1'b1, 0);
        run_op("t5", 16'hA5C3, 16'h3C5A, 1'b1, 3);

        // Abort after two RUN edges.
        a = 16'hFFFF; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6.in_ready", 32'(in_ready), 32'd1);
        chk("t6.out_valid", 32'(out_valid), 32'd0);
        chk("t6.diff", 32'(diff), 32'd0);
        chk("t6.busy", 32'(busy), 32'd0);
        for (int i = 0; i < NS; i++) begin
            @(posedge clk); #1;
            chk("t6.no_valid", 32'(out_valid), 32'd0);
        end
        run_op("t6b", 16'h0005, 16'h0003, 1'b0, 0);

        for (int n = 0; n < 24; n++) begin
            run_op("rnd", 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against any unexpected stall.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
Multi-cycle WIDTH-bit subtractor, the inverse companion of the team's 4-bit carry-lookahead adder slice. It computes A - B - bin one SLICE-bit nibble per clock, LSB slice first, chaining the borrow between slices. It uses a valid/ready handshake on both input and output and reports borrow, zero and signed-overflow flags. It sits in the ALU datapath wherever subtraction or compare is needed and area matters more than latency.

Parameters:
WIDTH, 16, operand and result width; must be a multiple of SLICE.
SLICE, 4, bits processed per cycle. NSLICE = WIDTH/SLICE.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous active-high reset.
in_valid  input  1  operands present on a/b/bin.
in_ready  output  1  block can accept operands; high only in IDLE.
a  input  WIDTH  minuend, unsigned or two's complement.
b  input  WIDTH  subtrahend.
bin  input  1  borrow-in.
out_valid  output  1  result and flags valid.
out_ready  input  1  consumer accepts result.
diff  output  WIDTH  a - b - bin, mod 2^WIDTH.
bout  output  1  final borrow; 1 iff unsigned a < b + bin.
zero  output  1  diff == 0.
ovf  output  1  signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
busy  output  1  state != IDLE.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, zero=0, ovf=0, busy=0, slice counter=0, work registers cleared.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b and bin into work registers, set borrow=bin and cnt=0, then go to RUN. Otherwise stay.
  - RUN: each edge processes slice cnt. Slice difference = a_s + ~b_s + ~borrow, computed as a SLICE-bit add with carry. borrow_next = ~carry_out. The slice result is written into the working result register and cnt increments.
  - RUN to DONE: after the edge that processes slice NSLICE-1. On that same edge, diff, bout, zero and ovf are loaded from the working registers and out_valid goes to 1.
  - DONE: out_valid=1. On out_ready, out_valid goes to 0 and state returns to IDLE. Otherwise hold.
- Latency: if operands are accepted at edge k, out_valid is high after edge k+NSLICE (4 cycles for the defaults).
- Throughput: one operation per NSLICE+2 cycles minimum. There is no accept in the same cycle as the output handshake; in_ready rises the cycle after the out_ready handshake.
- In_ready is 0 in RUN and DONE. in_valid and operand changes in those states are ignored and are not queued.
- Output registers diff, bout, zero and ovf change only on the RUN-to-DONE edge. They hold their previous values through IDLE and RUN, and stay stable while out_valid && !out_ready.
- The zero flag is evaluated on the full WIDTH-bit final result, not per slice.
- Borrow is chained across all slices. A borrow generated in slice 0 must reach the top slice, e.g. 0x0000-0x0001.
- Reset mid-operation (RUN or DONE) aborts the operation: no out_valid, and state returns to IDLE with the reset values listed above.
- rst has priority over every handshake in the same cycle.
- Operand values wrap modulo 2^WIDTH; there is no saturation.

Test Plan:
1. a=0x1234, b=0x0234, bin=0 accepted at edge k -> out_valid at k+4, diff=0x1000, bout=0, zero=0, ovf=0; in_ready=0 from k+1 until the output handshake.
2. a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, zero=0, ovf=0 (borrow ripples through all 4 slices).
3. a=0x8000, b=0x0001 -> diff=0x7FFF, ovf=1, bout=0. Then a=0x7FFF, b=0xFFFF -> diff=0x8000, ovf=1, bout=1.
4. a=0x00F0, b=0x00EF, bin=1 -> diff=0x0000, zero=1, bout=0, ovf=0.
5. Backpressure: hold out_ready=0 for 3 cycles after out_valid and drive in_valid=1 with new operands -> diff and flags stay stable, in_ready=0, new operands are not captured. Then raise out_ready -> out_valid=0 and in_ready=1 on the next cycle.
6. Assert rst for one cycle after 2 RUN edges -> next cycle state=IDLE, in_ready=1, out_valid=0, diff=0. Then a=0x0005, b=0x0003 -> diff=0x0002, with correct latency.
